// File: rtl/sum_sched.sv
// sum_sched: two-requester round-robin scheduler driving the shared 4-bit
// triangular-sum loop (sum += i; i++ while i < n). Each completed job returns
// result = n*(n-1)/2 mod 16 tagged with the requester id.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; arbitration happens here only
// GRANT | one-cycle accept pulse to cur_id, datapath loads n/i/sum
// LOOP  | accumulate while i < n_reg; exit cycle latches result/done_id
// DONE  | one-cycle completion pulse, then back to IDLE
module sum_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] n0,
  input  logic       req1,
  input  logic [3:0] n1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic [3:0] result,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOOP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] n_reg_q;
  logic [3:0] i_q;
  logic [3:0] sum_q;
  logic [3:0] result_q;
  logic       cur_id_q;
  logic       last_id_q;
  logic       done_id_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       busy_q;
  logic       done_q;

  logic       pick_id_d;
  logic [3:0] n_sel_d;
  logic [3:0] sum_d;
  logic [3:0] i_d;

  // Arbitration pick and datapath next values (adder wraps mod 16; the
  // incrementer never wraps because n_reg tops out at 15).
  always_comb begin
    pick_id_d = 1'b0;
    if (req0 && req1) begin
      pick_id_d = ~last_id_q;
    end else if (req1) begin
      pick_id_d = 1'b1;
    end
    n_sel_d = cur_id_q ? n1 : n0;
    sum_d   = sum_q + i_q;
    i_d     = i_q + 4'd1;
  end

  // Sequencer FSM with datapath registers and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_reg_q   <= 4'd0;
      i_q       <= 4'd0;
      sum_q     <= 4'd0;
      result_q  <= 4'd0;
      cur_id_q  <= 1'b0;
      last_id_q <= 1'b1;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            cur_id_q <= pick_id_d;
            gnt0_q   <= ~pick_id_d;
            gnt1_q   <= pick_id_d;
            busy_q   <= 1'b1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          n_reg_q   <= n_sel_d;
          i_q       <= 4'd0;
          sum_q     <= 4'd0;
          last_id_q <= cur_id_q;
          state_q   <= LOOP;
        end
        LOOP: begin
          if (i_q < n_reg_q) begin
            sum_q <= sum_d;
            i_q   <= i_d;
          end else begin
            result_q  <= sum_q;
            done_id_q <= cur_id_q;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_sum_sched.sv
// Directed bench for sum_sched: expected (id, result) pairs are queued at
// grant time from a reference model and popped when done pulses.
module tb_sum_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] n0, n1;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [3:0] result;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sum_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .n0      (n0),
    .req1    (req1),
    .n1      (n1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .result  (result),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  // Triangular sum computed the slow way, truncated to 4 bits.
  function automatic logic [3:0] tri_ref(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += k;
    return 4'(s % 16);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise a request, let IDLE sample it, and verify the grant in cycle 1.
  task automatic start_job(input bit id, input int n, input bit push);
    if (id) begin req1 = 1'b1; n1 = 4'(n); end
    else    begin req0 = 1'b1; n0 = 4'(n); end
    tick();
    cyc = 1;
    check(id ? "gnt1_c1" : "gnt0_c1", id ? int'(gnt1) : int'(gnt0), 1);
    check("other_gnt_c1", id ? int'(gnt0) : int'(gnt1), 0);
    check("busy_c1", int'(busy), 1);
    if (push) sb.push_back('{id: id, res: tri_ref(n)});
  endtask

  task automatic drop(input bit id);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  // Wait for done (bounded), check its cycle and scoreboard entry, then IDLE.
  task automatic finish_job(input int n);
    int   guard = 0;
    bit   saw_gnt = 0;
    exp_t e;
    while (done !== 1'b1 && guard < n + 20) begin
      tick();
      guard++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) saw_gnt = 1;
    end
    check("done_seen", int'(done), 1);
    if (done === 1'b1) begin
      check("done_cycle", cyc, n + 3);
      check("no_gnt_in_job", int'(saw_gnt), 0);
      check("busy_done", int'(busy), 1);
      check("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", int'(result), int'(e.res));
        check("done_id", int'(done_id), int'(e.id));
      end
      tick();
      check("done_pulse_1cyc", int'(done), 0);
      check("busy_idle", int'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; n0 = 4'd0; n1 = 4'd0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    check("rst_result", int'(result), 0);
    check("rst_done_id", int'(done_id), 0);
    for (int k = 0; k < 10; k++) begin
      check("idle_quiet", int'({gnt0, gnt1, busy, done}), 0);
      tick();
    end

    // Single job, n0=5 -> 10
    start_job(1'b0, 5, 1'b1);
    drop(1'b0);
    finish_job(5);

    // Bounds: n1=0 -> 0 (id 1), n0=15 -> 9
    start_job(1'b1, 0, 1'b1);
    drop(1'b1);
    finish_job(0);
    start_job(1'b0, 15, 1'b1);
    drop(1'b0);
    finish_job(15);

    // Round-robin from reset with both requests held
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; n0 = 4'd6; n1 = 4'd7;
    tick(); tick();
    rst = 1'b0;
    start_job(1'b0, 6, 1'b1);
    drop(1'b0);
    finish_job(6);
    start_job(1'b1, 7, 1'b1);
    check("rr_gnt_2_after_done", cyc, 1);
    drop(1'b1);
    finish_job(7);
    req0 = 1'b1; req1 = 1'b1; n0 = 4'd3; n1 = 4'd2;
    start_job(1'b0, 3, 1'b1);
    drop(1'b0);
    finish_job(3);
    start_job(1'b1, 2, 1'b1);
    drop(1'b1);
    finish_job(2);

    // Mid-job contention: req1 arrives in LOOP of a requester-0 job
    start_job(1'b0, 4, 1'b1);
    drop(1'b0);
    tick(); tick();
    req1 = 1'b1; n1 = 4'd3;
    finish_job(4);
    start_job(1'b1, 3, 1'b1);
    drop(1'b1);
    finish_job(3);

    // Reset in the 3rd LOOP cycle of n0=9; req0 stays high and re-grants
    start_job(1'b0, 9, 1'b0);
    tick(); tick(); tick();
    check("abort_no_done", int'(done), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_done_id", int'(done_id), 0);
    check("abort_gnt0", int'(gnt0), 0);
    start_job(1'b0, 9, 1'b1);
    drop(1'b0);
    finish_job(9);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
